// File: rtl/pet_tap_player_pkg.sv
// Shared types and constants for the PET cassette .TAP player.
package pet_tap_pkg;

  localparam int HDR_LEN      = 20;
  localparam int CYC_PER_UNIT = 8;
  localparam int CNT_W        = 24;
  localparam int TAP_VER_OFS  = 12;
  localparam int TAP_LEN_OFS  = 16;

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  typedef enum logic [3:0] {
    IDLE, HDR, FETCH, LONG0, LONG1, LONG2, PULSE, DONE, ERR
  } tap_state_t;

  // Convert a TAP count (1..256 units) into ce_1m ticks, saturating at the counter width.
  function automatic logic [CNT_W-1:0] short_ticks(input logic [8:0] units);
    logic [31:0] p;
    p = 32'(units) * 32'(CYC_PER_UNIT);
    if (p > CNT_MAX) begin
      short_ticks = '1;
    end else begin
      short_ticks = p[CNT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/pet_tap_player_if.sv
// Byte stream from the loader FIFO into the TAP player (valid/ready pop handshake).
interface pet_tap_player_if;
  logic       tap_valid;
  logic [7:0] tap_data;
  logic       tap_ready;

  modport master (output tap_valid, output tap_data, input tap_ready);
  modport slave  (input tap_valid, input tap_data, output tap_ready);
endinterface

// File: rtl/pet_tap_player_pulse_gen.sv
// Pulse timer: counts one TAP pulse down in ce_1m ticks and shapes cass_read
// low for the first (ceil) half and high for the remaining floor(orig/2) ticks.
module pet_tap_pulse_gen
  import pet_tap_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             tick,
  output logic             pin,
  output logic             last
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] half_r;
  logic [CNT_W-1:0] cnt_dec_s;

  assign cnt_dec_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
  assign last      = tick & (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1});

  // Countdown and pin shaping; the pin idles high whenever no pulse is running.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      cnt_r  <= '0;
      half_r <= '0;
      pin    <= 1'b1;
    end else if (load) begin
      cnt_r  <= cnt_in;
      half_r <= cnt_in >> 1;
      pin    <= !(cnt_in > (cnt_in >> 1));
    end else if (tick && (cnt_r != '0)) begin
      cnt_r  <= cnt_dec_s;
      pin    <= !(cnt_dec_s > half_r);
    end else begin
      cnt_r  <= cnt_r;
    end
  end

endmodule

// File: rtl/pet_tap_player.sv
// PET datasette front end: parses the .TAP header, fetches pulse lengths and
// replays them on cass_read while PLAY is held and the PET runs the motor.
module pet_tap_player
  import pet_tap_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_1m,
  input  logic              play,
  input  logic              rewind,
  input  logic              cass_motor_n,
  pet_tap_player_if.slave   tap,
  output logic              cass_sense_n,
  output logic              cass_read,
  output logic              busy,
  output logic              done,
  output logic              error
);

  tap_state_t       state_r;
  logic [4:0]       hdr_idx_r;
  logic [7:0]       ver_r;
  logic [31:0]      len_r;
  logic [15:0]      long_r;
  logic             run_s;
  logic             ready_en_s;
  logic             pop_s;
  logic             load_s;
  logic             tick_s;
  logic             last_s;
  logic [CNT_W-1:0] cnt_in_s;
  logic [CNT_W-1:0] long_val_s;
  logic [31:0]      len_hdr_s;

  assign run_s      = play & ~cass_motor_n;
  assign ready_en_s = run_s & reset_n & ~rewind;
  assign pop_s      = tap.tap_valid & tap.tap_ready;
  assign tick_s     = ce_1m & run_s & (state_r == PULSE);
  assign long_val_s = {tap.tap_data, long_r};
  assign len_hdr_s  = {tap.tap_data, len_r[31:8]};

  // Pop strobe: only in byte-consuming states; a LONG state with no bytes left does not pop.
  always_comb begin
    case (state_r)
      HDR, FETCH:          tap.tap_ready = ready_en_s;
      LONG0, LONG1, LONG2: tap.tap_ready = ready_en_s & (len_r != 32'd0);
      default:             tap.tap_ready = 1'b0;
    endcase
  end

  // Pulse load decode: short pulse from FETCH, or the completed 24-bit value in LONG2.
  always_comb begin
    load_s   = 1'b0;
    cnt_in_s = '0;
    if (pop_s && (state_r == FETCH)) begin
      if (tap.tap_data != 8'd0) begin
        load_s   = 1'b1;
        cnt_in_s = short_ticks({1'b0, tap.tap_data});
      end else if (ver_r == 8'd0) begin
        load_s   = 1'b1;
        cnt_in_s = short_ticks(9'd256);
      end else begin
        load_s   = 1'b0;
        cnt_in_s = '0;
      end
    end else if (pop_s && (state_r == LONG2)) begin
      load_s   = 1'b1;
      cnt_in_s = (long_val_s == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : long_val_s;
    end else begin
      load_s   = 1'b0;
      cnt_in_s = '0;
    end
  end

  // Main FSM with header parser; everything freezes while run is low.
  always_ff @(posedge clk) begin
    if (!reset_n || rewind) begin
      state_r   <= IDLE;
      hdr_idx_r <= 5'd0;
      ver_r     <= 8'd0;
      len_r     <= 32'd0;
      long_r    <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (run_s) begin
            state_r   <= HDR;
            hdr_idx_r <= 5'd0;
          end
        end
        HDR: begin
          if (pop_s) begin
            if (hdr_idx_r == 5'(TAP_VER_OFS)) ver_r <= tap.tap_data;
            if (hdr_idx_r >= 5'(TAP_LEN_OFS)) len_r <= len_hdr_s;
            if (hdr_idx_r == 5'(HDR_LEN - 1)) begin
              if (ver_r > 8'd1)              state_r <= ERR;
              else if (len_hdr_s == 32'd0)   state_r <= DONE;
              else                           state_r <= FETCH;
            end else begin
              hdr_idx_r <= hdr_idx_r + 5'd1;
            end
          end
        end
        FETCH: begin
          if (pop_s) begin
            len_r   <= len_r - 32'd1;
            state_r <= load_s ? PULSE : LONG0;
          end
        end
        LONG0: begin
          if (run_s && (len_r == 32'd0)) begin
            state_r <= DONE;
          end else if (pop_s) begin
            long_r[7:0] <= tap.tap_data;
            len_r       <= len_r - 32'd1;
            state_r     <= LONG1;
          end
        end
        LONG1: begin
          if (run_s && (len_r == 32'd0)) begin
            state_r <= DONE;
          end else if (pop_s) begin
            long_r[15:8] <= tap.tap_data;
            len_r        <= len_r - 32'd1;
            state_r      <= LONG2;
          end
        end
        LONG2: begin
          if (run_s && (len_r == 32'd0)) begin
            state_r <= DONE;
          end else if (pop_s) begin
            len_r   <= len_r - 32'd1;
            state_r <= PULSE;
          end
        end
        PULSE: begin
          if (last_s) state_r <= (len_r == 32'd0) ? DONE : FETCH;
        end
        DONE, ERR: state_r <= state_r;
        default:   state_r <= IDLE;
      endcase
    end
  end

  // Registered status flags and PLAY sense line.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cass_sense_n <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      cass_sense_n <= ~play;
      busy         <= ~rewind & (state_r inside {HDR, FETCH, LONG0, LONG1, LONG2, PULSE});
      done         <= ~rewind & (state_r == DONE);
      error        <= ~rewind & (state_r == ERR);
    end
  end

  pet_tap_pulse_gen u_pulse (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (rewind),
    .load    (load_s),
    .cnt_in  (cnt_in_s),
    .tick    (tick_s),
    .pin     (cass_read),
    .last    (last_s)
  );

endmodule

// File: tb/tb_pet_tap_player.sv
// Testbench for pet_tap_player: directed TAP streams, scoreboard of expected
// pulse low/high tick counts checked by an independent cass_read monitor.
`timescale 1ns/1ps
module tb_pet_tap_player;
  import pet_tap_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce_1m = 1'b0;
  logic play = 1'b0;
  logic rewind = 1'b0;
  logic cass_motor_n = 1'b1;
  logic cass_sense_n, cass_read, busy, done, error;

  pet_tap_player_if tif();

  pet_tap_player dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ce_1m        (ce_1m),
    .play         (play),
    .rewind       (rewind),
    .cass_motor_n (cass_motor_n),
    .tap          (tif),
    .cass_sense_n (cass_sense_n),
    .cass_read    (cass_read),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  typedef struct {int lo; int hi;} pulse_t;
  pulse_t     exp_q[$];
  logic [7:0] stream[$];
  logic [7:0] taken[$];
  int         pop_cnt = 0;
  bit         stall = 1'b0;
  bit         mon_clr = 1'b1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic exp_pulse(input int lo, input int hi);
    pulse_t p;
    p.lo = lo;
    p.hi = hi;
    exp_q.push_back(p);
  endtask

  task automatic emit(input int lo, input int hi);
    pulse_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse: got lo=%0d hi=%0d expected no pulse", lo, hi);
    end else begin
      e = exp_q.pop_front();
      check("pulse_low_ticks", lo, e.lo);
      if (e.hi >= 0) check("pulse_high_ticks", hi, e.hi);
    end
  endtask

  task automatic load_hdr(input logic [7:0] ver, input logic [31:0] len);
    stream.delete();
    for (int i = 0; i < HDR_LEN; i++) begin
      logic [7:0] b;
      if (i == 0)                 b = 8'h43;
      else if (i == TAP_VER_OFS)  b = ver;
      else if (i >= TAP_LEN_OFS)  b = len[8*(i-TAP_LEN_OFS) +: 8];
      else                        b = 8'(8'h41 + i);
      stream.push_back(b);
    end
  endtask

  task automatic wait_flag(input string name, input int budget, input bit want_err);
    int n = 0;
    while (n < budget && !(want_err ? error : done)) begin
      @(negedge clk);
      n++;
    end
    check(name, want_err ? error : done, 1);
  endtask

  task automatic prep();
    play = 1'b0;
    cyc(2);
    rewind = 1'b1;
    mon_clr = 1'b1;
    cyc(1);
    rewind = 1'b0;
    stream.delete();
    taken.delete();
    exp_q.delete();
    pop_cnt = 0;
    stall = 1'b0;
    cyc(2);
    mon_clr = 1'b0;
  endtask

  // 1 MHz enable: one tick every other clk
  initial begin : ce_gen
    forever begin
      @(posedge clk);
      #2;
      ce_1m = ~ce_1m;
    end
  end

  // Loader FIFO model: presents stream head, retires it when the DUT pops
  initial begin : feeder
    bit take;
    tif.tap_valid = 1'b0;
    tif.tap_data  = 8'h00;
    forever begin
      @(negedge clk);
      take = tif.tap_valid && tif.tap_ready;
      @(posedge clk);
      #3;
      if (take && stream.size() > 0) begin
        taken.push_back(stream.pop_front());
        pop_cnt++;
      end
      if (stream.size() > 0 && !stall) begin
        tif.tap_valid = 1'b1;
        tif.tap_data  = stream[0];
      end else begin
        tif.tap_valid = 1'b0;
        tif.tap_data  = 8'h00;
      end
    end
  end

  // Monitor: measures low/high tick counts of each pulse on cass_read
  initial begin : monitor
    int lo;
    int hi;
    lo = 0;
    hi = 0;
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        lo = 0;
        hi = 0;
      end else if (done && lo > 0) begin
        emit(lo, hi);
        lo = 0;
        hi = 0;
      end else if (ce_1m && play && !cass_motor_n) begin
        if (cass_read == 1'b0) begin
          if (hi > 0) begin
            emit(lo, hi);
            lo = 0;
            hi = 0;
          end
          lo++;
        end else if (lo > 0) begin
          hi++;
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int pc;
    reset_n = 1'b0;
    cyc(3);
    @(negedge clk);
    check("rst_cass_read", cass_read, 1);
    check("rst_sense_n", cass_sense_n, 1);
    check("rst_tap_ready", tif.tap_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    cyc(1);
    reset_n = 1'b1;
    mon_clr = 1'b0;

    // T1: reset in the middle of a long short-pulse
    load_hdr(8'd0, 32'd1);
    stream.push_back(8'hFF);
    cass_motor_n = 1'b0;
    play = 1'b1;
    cyc(300);
    @(negedge clk);
    check("t1_midpulse_low", cass_read, 0);
    cyc(1);
    mon_clr = 1'b1;
    reset_n = 1'b0;
    play = 1'b0;
    cyc(1);
    @(negedge clk);
    check("t1_rst_cass_read", cass_read, 1);
    check("t1_rst_tap_ready", tif.tap_ready, 0);
    check("t1_rst_busy", busy, 0);
    cyc(1);
    reset_n = 1'b1;
    stream.delete();
    taken.delete();
    exp_q.delete();
    pop_cnt = 0;
    cyc(2);
    mon_clr = 1'b0;

    // T2: v0 short pulses 0x30 and 0x00 (=256 units)
    load_hdr(8'd0, 32'd2);
    stream.push_back(8'h30);
    stream.push_back(8'h00);
    exp_pulse(192, 192);
    exp_pulse(1024, 1024);
    play = 1'b1;
    wait_flag("t2_done", 7000, 1'b0);
    cyc(2);
    check("t1_first_byte_after_reset", (taken.size() > 0) ? 32'(taken[0]) : 32'hFFFF, 32'h43);
    check("t2_pulses_left", exp_q.size(), 0);
    check("t2_pops", pop_cnt, 22);
    check("t2_cass_read_idle", cass_read, 1);

    // T3: v1 long pulse 0x002710
    prep();
    load_hdr(8'd1, 32'd4);
    stream.push_back(8'h00);
    stream.push_back(8'h10);
    stream.push_back(8'h27);
    stream.push_back(8'h00);
    exp_pulse(5000, 5000);
    play = 1'b1;
    wait_flag("t3_done", 22000, 1'b0);
    cyc(2);
    check("t3_pulses_left", exp_q.size(), 0);
    check("t3_pops", pop_cnt, 24);
    check("t3_cass_read_idle", cass_read, 1);

    // T4: motor pause in the middle of a 0x40 pulse
    prep();
    load_hdr(8'd0, 32'd1);
    stream.push_back(8'h40);
    exp_pulse(256, 256);
    play = 1'b1;
    cyc(300);
    pc = pop_cnt;
    cass_motor_n = 1'b1;
    cyc(600);
    @(negedge clk);
    check("t4_frozen_low", cass_read, 0);
    check("t4_no_pops", pop_cnt, pc);
    check("t4_ready_paused", tif.tap_ready, 0);
    check("t4_busy_paused", busy, 1);
    cyc(1);
    cass_motor_n = 1'b0;
    wait_flag("t4_done", 2000, 1'b0);
    cyc(2);
    check("t4_pulses_left", exp_q.size(), 0);

    // T5a: FIFO underrun while waiting in FETCH
    prep();
    load_hdr(8'd0, 32'd2);
    stream.push_back(8'h10);
    stream.push_back(8'h08);
    exp_pulse(64, -1);
    exp_pulse(32, 32);
    play = 1'b1;
    cyc(100);
    stall = 1'b1;
    cyc(230);
    @(negedge clk);
    check("t5_underrun_ready", tif.tap_ready, 1);
    check("t5_underrun_read_high", cass_read, 1);
    check("t5_underrun_busy", busy, 1);
    cyc(1);
    stall = 1'b0;
    wait_flag("t5_done", 1000, 1'b0);
    cyc(2);
    check("t5_pulses_left", exp_q.size(), 0);

    // T5b: unsupported header version
    prep();
    load_hdr(8'd2, 32'd5);
    repeat (5) stream.push_back(8'h20);
    play = 1'b1;
    wait_flag("t5_error", 200, 1'b1);
    check("t5_err_cass_read", cass_read, 1);
    check("t5_err_done", done, 0);
    cyc(3);
    check("t5_err_pops", pop_cnt, 20);
    play = 1'b0;
    cyc(1);
    rewind = 1'b1;
    cyc(1);
    rewind = 1'b0;
    cyc(2);
    @(negedge clk);
    check("t5_rewind_error", error, 0);
    check("t5_rewind_busy", busy, 0);
    check("t5_rewind_ready", tif.tap_ready, 0);

    // T6: sense line follows PLAY with one clk latency, motor off
    prep();
    cass_motor_n = 1'b1;
    cyc(2);
    for (int i = 0; i < 4; i++) begin
      bit v;
      v = (i % 2 == 0);
      play = v;
      @(negedge clk);
      check("t6_sense_before_edge", cass_sense_n, v);
      check("t6_ready_off", tif.tap_ready, 0);
      cyc(1);
      @(negedge clk);
      check("t6_sense_after_edge", cass_sense_n, !v);
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
